pipe_ctrl: RTL

Pipelined control unit for the 5-stage processor: decodes the ID-stage opcode into the standard control bundle and carries it through the ID/EX, EX/MEM and MEM/WB stage registers. It also detects hazards and generates PC/IF-ID hold, flush and bubble controls. Multi-cycle MUL occupancy is parameterised. Operand forwarding selects are optional. It replaces the single-cycle decoder between the IF/ID register and the datapath.

---
 rtl/pipe_ctrl.sv | 299 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipelined control unit for the 5-stage processor.
//
// Decodes the ID-stage opcode into the 13-bit control bundle
//   {jr, jal, jump, aluop[2:0], branch, memToReg, memRead, memWrite, regDst, alusrc, wen}
// and carries it through the ID/EX, EX/MEM and MEM/WB stage registers.
// Also produces the PC / IF-ID hold, IF-ID flush and ID/EX bubble controls.
//
// Optional feature macro: PIPE_CTRL_FWD_EN
//   defined   : EX operand forwarding selects are produced; only load-use stalls.
//   undefined : fwd_a/fwd_b are 00; any EX or MEM writer of a used ID source stalls.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   id_valid, id_op           IF/ID instruction present, opcode
//   id_rs, id_rt, id_rd       IF/ID register fields
//   ex_br_taken               BEQ compare result from the EX datapath
//   pc_hold, ifid_hold        freeze PC and IF/ID
//   ifid_flush                load NOP into IF/ID on the next edge
//   ex/mem/wb_ctrl, _rd       per-stage control bundle and destination register
//   fwd_a, fwd_b              EX operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB
module pipe_ctrl #(
  parameter int OPW      = 4,
  parameter int RAW      = 3,
  parameter int MUL_LAT  = 3,
  parameter int LINK_REG = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           id_valid,
  input  logic [OPW-1:0] id_op,
  input  logic [RAW-1:0] id_rs,
  input  logic [RAW-1:0] id_rt,
  input  logic [RAW-1:0] id_rd,
  input  logic           ex_br_taken,
  output logic           pc_hold,
  output logic           ifid_hold,
  output logic           ifid_flush,
  output logic [12:0]    ex_ctrl,
  output logic [12:0]    mem_ctrl,
  output logic [12:0]    wb_ctrl,
  output logic [RAW-1:0] ex_rd,
  output logic [RAW-1:0] mem_rd,
  output logic [RAW-1:0] wb_rd,
  output logic [1:0]     fwd_a,
  output logic [1:0]     fwd_b
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_COM  = 4'd4;
  localparam logic [3:0] OP_MUL  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_LW   = 4'd8;
  localparam logic [3:0] OP_SW   = 4'd9;
  localparam logic [3:0] OP_BEQ  = 4'd10;
  localparam logic [3:0] OP_JUMP = 4'd11;
  localparam logic [3:0] OP_JAL  = 4'd12;
  localparam logic [3:0] OP_JR   = 4'd13;

  // Bundle bit positions
  localparam int B_WEN  = 0;
  localparam int B_ASRC = 1;
  localparam int B_RDST = 2;
  localparam int B_MWR  = 3;
  localparam int B_MRD  = 4;
  localparam int B_M2R  = 5;
  localparam int B_BR   = 6;
  localparam int B_ALU  = 7;
  localparam int B_JMP  = 10;
  localparam int B_JAL  = 11;
  localparam int B_JR   = 12;

  localparam int CW = $clog2(MUL_LAT) + 1;

  // A used source register (non-zero) matches a producer's destination
  function automatic logic src_hit(input logic uses, input logic [RAW-1:0] rs,
                                   input logic [RAW-1:0] rt, input logic [RAW-1:0] rd);
    return uses && (((rs != {RAW{1'b0}}) && (rs == rd)) ||
                    ((rt != {RAW{1'b0}}) && (rt == rd)));
  endfunction

  logic [12:0]    ex_ctrl_q, ex_ctrl_d, mem_ctrl_q, mem_ctrl_d, wb_ctrl_q, wb_ctrl_d;
  logic [RAW-1:0] ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
  logic           ex_mul_q, ex_mul_d;
  logic [CW-1:0]  mul_cnt_q, mul_cnt_d;

  logic [12:0]    id_ctrl_s;
  logic           id_uses_s;
  logic           op_hi_zero_s;
  logic           id_is_mul_s;
  logic [RAW-1:0] id_rd_s;
  logic           br_flush_s, mul_busy_s, data_stall_s;
  logic           hold_s, flush_s;
  logic [1:0]     fwd_a_s, fwd_b_s;

  // Opcode bits above the 4-bit encoding must be zero for a valid decode
  assign op_hi_zero_s = ((id_op >> 4) == {OPW{1'b0}});
  assign id_is_mul_s  = id_valid && op_hi_zero_s && (id_op[3:0] == OP_MUL);
  assign id_rd_s      = id_ctrl_s[B_JAL] ? RAW'(LINK_REG) : id_rd;

  // ID-stage decode into the control bundle and source-usage flag
  always_comb begin
    id_ctrl_s = 13'd0;
    id_uses_s = 1'b0;
    if (id_valid && op_hi_zero_s) begin
      case (id_op[3:0])
        OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_COM, OP_MUL: begin
          id_ctrl_s[B_WEN]       = 1'b1;
          id_ctrl_s[B_M2R]       = 1'b1;
          id_ctrl_s[B_ALU +: 3]  = id_op[2:0];
          id_uses_s              = 1'b1;
        end
        OP_SLL, OP_SRL: begin
          id_ctrl_s[B_WEN]       = 1'b1;
          id_ctrl_s[B_M2R]       = 1'b1;
          id_ctrl_s[B_ASRC]      = 1'b1;
          id_ctrl_s[B_ALU +: 3]  = id_op[2:0];
          id_uses_s              = 1'b1;
        end
        OP_LW: begin
          id_ctrl_s[B_WEN]  = 1'b1;
          id_ctrl_s[B_ASRC] = 1'b1;
          id_ctrl_s[B_MRD]  = 1'b1;
          id_uses_s         = 1'b1;
        end
        OP_SW: begin
          id_ctrl_s[B_ASRC] = 1'b1;
          id_ctrl_s[B_RDST] = 1'b1;
          id_ctrl_s[B_MWR]  = 1'b1;
          id_uses_s         = 1'b1;
        end
        OP_BEQ: begin
          id_ctrl_s[B_BR]   = 1'b1;
          id_ctrl_s[B_RDST] = 1'b1;
          id_uses_s         = 1'b1;
        end
        OP_JUMP: begin
          id_ctrl_s[B_JMP] = 1'b1;
        end
        OP_JAL: begin
          id_ctrl_s[B_WEN] = 1'b1;
          id_ctrl_s[B_JMP] = 1'b1;
          id_ctrl_s[B_JAL] = 1'b1;
        end
        OP_JR: begin
          id_ctrl_s[B_JR] = 1'b1;
          id_uses_s       = 1'b1;
        end
        default: begin
          id_ctrl_s = 13'd0;
          id_uses_s = 1'b0;
        end
      endcase
    end else begin
      id_ctrl_s = 13'd0;
      id_uses_s = 1'b0;
    end
  end

  assign br_flush_s = ex_ctrl_q[B_BR] & ex_br_taken;
  // MUL keeps EX occupied until its counter reaches MUL_LAT-1
  assign mul_busy_s = ex_mul_q & (mul_cnt_q < CW'(MUL_LAT - 1));

`ifdef PIPE_CTRL_FWD_EN
  logic [RAW-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;

  // EX/MEM result takes priority over the older MEM/WB result
  function automatic logic [1:0] fwd_sel(input logic [RAW-1:0] src,
                                         input logic m_wen, input logic [RAW-1:0] m_rd,
                                         input logic w_wen, input logic [RAW-1:0] w_rd);
    logic [1:0] sel;
    if (m_wen && (m_rd != {RAW{1'b0}}) && (m_rd == src)) begin
      sel = 2'b01;
    end else if (w_wen && (w_rd != {RAW{1'b0}}) && (w_rd == src)) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign data_stall_s = ex_ctrl_q[B_MRD] & src_hit(id_uses_s, id_rs, id_rt, ex_rd_q);
  assign fwd_a_s = fwd_sel(ex_rs_q, mem_ctrl_q[B_WEN], mem_rd_q, wb_ctrl_q[B_WEN], wb_rd_q);
  assign fwd_b_s = fwd_sel(ex_rt_q, mem_ctrl_q[B_WEN], mem_rd_q, wb_ctrl_q[B_WEN], wb_rd_q);

  // Source fields follow the ID/EX register: hold with it, clear on bubble
  always_comb begin
    ex_rs_d = ex_rs_q;
    ex_rt_d = ex_rt_q;
    if (br_flush_s) begin
      ex_rs_d = {RAW{1'b0}};
      ex_rt_d = {RAW{1'b0}};
    end else if (mul_busy_s) begin
      ex_rs_d = ex_rs_q;
      ex_rt_d = ex_rt_q;
    end else if (data_stall_s) begin
      ex_rs_d = {RAW{1'b0}};
      ex_rt_d = {RAW{1'b0}};
    end else begin
      ex_rs_d = id_rs;
      ex_rt_d = id_rt;
    end
  end

  // Forwarding source-field registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rs_q <= {RAW{1'b0}};
      ex_rt_q <= {RAW{1'b0}};
    end else begin
      ex_rs_q <= ex_rs_d;
      ex_rt_q <= ex_rt_d;
    end
  end
`else
  // Without forwarding, any pending writer in EX or MEM must drain first;
  // WB is visible through the write-first register file.
  assign data_stall_s = (ex_ctrl_q[B_WEN]  & src_hit(id_uses_s, id_rs, id_rt, ex_rd_q)) |
                        (mem_ctrl_q[B_WEN] & src_hit(id_uses_s, id_rs, id_rt, mem_rd_q));
  assign fwd_a_s = 2'b00;
  assign fwd_b_s = 2'b00;
`endif

  // Priority resolution: branch flush > MUL hold > data stall > jump flush
  always_comb begin
    ex_ctrl_d  = ex_ctrl_q;
    ex_rd_d    = ex_rd_q;
    ex_mul_d   = ex_mul_q;
    mem_ctrl_d = ex_ctrl_q;
    mem_rd_d   = ex_rd_q;
    wb_ctrl_d  = mem_ctrl_q;
    wb_rd_d    = mem_rd_q;
    mul_cnt_d  = {CW{1'b0}};
    hold_s     = 1'b0;
    flush_s    = 1'b0;
    if (br_flush_s) begin
      flush_s   = 1'b1;
      ex_ctrl_d = 13'd0;
      ex_rd_d   = {RAW{1'b0}};
      ex_mul_d  = 1'b0;
    end else if (mul_busy_s) begin
      // ID/EX keeps the MUL; a bubble enters EX/MEM behind it
      hold_s     = 1'b1;
      mem_ctrl_d = 13'd0;
      mem_rd_d   = {RAW{1'b0}};
      mul_cnt_d  = mul_cnt_q + CW'(1);
    end else if (data_stall_s) begin
      hold_s    = 1'b1;
      ex_ctrl_d = 13'd0;
      ex_rd_d   = {RAW{1'b0}};
      ex_mul_d  = 1'b0;
    end else begin
      ex_ctrl_d = id_ctrl_s;
      ex_rd_d   = id_rd_s;
      ex_mul_d  = id_is_mul_s;
      flush_s   = id_ctrl_s[B_JMP] | id_ctrl_s[B_JR];
    end
  end

  // Stage registers and MUL occupancy counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_ctrl_q  <= 13'd0;
      mem_ctrl_q <= 13'd0;
      wb_ctrl_q  <= 13'd0;
      ex_rd_q    <= {RAW{1'b0}};
      mem_rd_q   <= {RAW{1'b0}};
      wb_rd_q    <= {RAW{1'b0}};
      ex_mul_q   <= 1'b0;
      mul_cnt_q  <= {CW{1'b0}};
    end else begin
      ex_ctrl_q  <= ex_ctrl_d;
      mem_ctrl_q <= mem_ctrl_d;
      wb_ctrl_q  <= wb_ctrl_d;
      ex_rd_q    <= ex_rd_d;
      mem_rd_q   <= mem_rd_d;
      wb_rd_q    <= wb_rd_d;
      ex_mul_q   <= ex_mul_d;
      mul_cnt_q  <= mul_cnt_d;
    end
  end

  // Hazard outputs are forced low while reset is asserted, even with a jump in ID
  assign pc_hold    = hold_s  & ~rst;
  assign ifid_hold  = hold_s  & ~rst;
  assign ifid_flush = flush_s & ~rst;
  assign fwd_a      = fwd_a_s & {2{~rst}};
  assign fwd_b      = fwd_b_s & {2{~rst}};
  assign ex_ctrl    = ex_ctrl_q;
  assign mem_ctrl   = mem_ctrl_q;
  assign wb_ctrl    = wb_ctrl_q;
  assign ex_rd      = ex_rd_q;
  assign mem_rd     = mem_rd_q;
  assign wb_rd      = wb_rd_q;

endmodule
